// File: rtl/alu_mc_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the multi-cycle ALU.
// Imported by alu_mc and alu_mc_iter.
package alu_mc_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_NOT  = 4'h5;
    localparam logic [3:0] ALU_INC  = 4'h6;
    localparam logic [3:0] ALU_DEC  = 4'h7;
    localparam logic [3:0] ALU_RL   = 4'h8;
    localparam logic [3:0] ALU_RR   = 4'h9;
    localparam logic [3:0] ALU_RLC  = 4'hA;
    localparam logic [3:0] ALU_RRC  = 4'hB;
    localparam logic [3:0] ALU_SWAP = 4'hC;
    localparam logic [3:0] ALU_MUL  = 4'hD;
    localparam logic [3:0] ALU_DIV  = 4'hE;
    localparam logic [3:0] ALU_RSVD = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // Divide by zero never iterates; it finishes like a single-cycle op.
    function automatic logic is_iter_op(input logic [3:0] op, input logic divisor_zero);
        return (op == ALU_MUL) || ((op == ALU_DIV) && !divisor_zero);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared W-step shift datapath: LSB-first shift-add multiply or restoring divide.
// hi_o/lo_o show the value after the current step; last_o marks the final step.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             mul_mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    always_comb begin
        sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, b_q} : '0);
        trial = {acc_q, sh_q[WIDTH-1]};
        diff  = trial - {1'b0, b_q};
        acc_d = acc_q;
        sh_d  = sh_q;
        if (mul_mode_i) begin
            acc_d = sum[WIDTH:1];
            sh_d  = {sum[0], sh_q[WIDTH-1:1]};
        end else begin
            // diff[WIDTH] set means the trial subtraction borrowed: restore.
            acc_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            sh_d  = {sh_q[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    assign last_o = run_q && (cnt_q == CW'(WIDTH - 1));
    assign hi_o   = acc_d;
    assign lo_o   = sh_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            sh_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= '0;
            sh_q  <= a_i;
            b_q   <= b_i;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            cnt_q <= cnt_q + CW'(1);
            if (last_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative MUL and DIV behind
// a start/done handshake; results and flags are registered and held.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    output logic             busy,
    output logic             done,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cpu_carry,
    output logic [WIDTH-1:0] result_l,
    output logic [WIDTH-1:0] result_h,
    output logic             carry,
    output logic             zero,
    output logic             sign,
    output logic             div_err,
    output logic [1:0]       dbg_state
);

    // Handshake: a request is taken on any rising edge where start && ready;
    // done pulses for exactly the cycle in which result/flag registers changed.
    state_e           state_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cin_q;
    logic             pend_q;
    logic             load_q;
    logic             done_q;
    logic [WIDTH-1:0] result_l_q, result_h_q;
    logic             carry_q, zero_q, sign_q, div_err_q;

    logic             accept;
    logic             it_last;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH-1:0] al_l, al_h;
    logic             al_c, al_z, al_s, al_e;
    logic [WIDTH:0]   add_w;

    assign accept = start && (state_q == ST_IDLE);

    alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_q),
        .mul_mode_i (state_q == ST_MUL),
        .a_i        (a_q),
        .b_i        (b_q),
        .last_o     (it_last),
        .hi_o       (it_hi),
        .lo_o       (it_lo)
    );

    always_comb begin
        al_l  = '0;
        al_h  = '0;
        al_c  = 1'b0;
        al_z  = 1'b0;
        al_s  = 1'b0;
        al_e  = 1'b0;
        add_w = '0;
        case (op_q)
            ALU_ADD: begin
                add_w = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
                al_c  = add_w[WIDTH];
                al_l  = add_w[WIDTH-1:0];
                al_z  = (al_l == '0);
            end
            ALU_SUB: begin
                if (a_q >= b_q) begin
                    al_l = a_q - b_q;
                end else begin
                    al_l = b_q - a_q;
                    al_s = 1'b1;
                end
                al_z = (a_q == b_q);
            end
            ALU_AND: begin al_l = a_q & b_q; al_z = (al_l == '0); end
            ALU_OR:  begin al_l = a_q | b_q; al_z = (al_l == '0); end
            ALU_XOR: begin al_l = a_q ^ b_q; al_z = (al_l == '0); end
            ALU_NOT: begin al_l = ~a_q;      al_z = (al_l == '0); end
            ALU_INC: begin
                al_l = a_q + WIDTH'(1);
                al_c = &a_q;
                al_z = &a_q;
            end
            ALU_DEC: begin
                if (a_q == '0) begin
                    al_l = WIDTH'(1);
                    al_s = 1'b1;
                end else begin
                    al_l = a_q - WIDTH'(1);
                end
                al_z = (a_q == WIDTH'(1));
            end
            ALU_RL:  begin al_l = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; al_z = (a_q == '0); end
            ALU_RR:  begin al_l = {a_q[0], a_q[WIDTH-1:1]};       al_z = (a_q == '0); end
            ALU_RLC: begin
                al_l = {a_q[WIDTH-2:0], cin_q};
                al_c = a_q[WIDTH-1];
                al_z = (al_l == '0);
            end
            ALU_RRC: begin
                al_l = {cin_q, a_q[WIDTH-1:1]};
                al_c = a_q[0];
                al_z = (al_l == '0);
            end
            ALU_SWAP: begin
                al_l = {a_q[WIDTH/2-1:0], a_q[WIDTH-1:WIDTH/2]};
                al_z = (a_q == '0);
            end
            // Only the divide-by-zero case of DIV reaches the single-cycle path.
            ALU_DIV: begin
                al_e = 1'b1;
                al_l = '1;
                al_h = a_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            pend_q     <= 1'b0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            result_l_q <= '0;
            result_h_q <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            sign_q     <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            pend_q <= 1'b0;
            load_q <= 1'b0;
            if (accept) begin
                op_q  <= op;
                a_q   <= op1;
                b_q   <= op2;
                cin_q <= cpu_carry;
                if (is_iter_op(op, op2 == '0)) begin
                    state_q <= (op == ALU_MUL) ? ST_MUL : ST_DIV;
                    load_q  <= 1'b1;
                end else begin
                    pend_q <= 1'b1;
                end
            end
            if (pend_q) begin
                result_l_q <= al_l;
                result_h_q <= al_h;
                carry_q    <= al_c;
                zero_q     <= al_z;
                sign_q     <= al_s;
                div_err_q  <= al_e;
                done_q     <= 1'b1;
            end
            if (it_last) begin
                result_l_q <= it_lo;
                result_h_q <= it_hi;
                carry_q    <= 1'b0;
                sign_q     <= 1'b0;
                div_err_q  <= 1'b0;
                zero_q     <= (state_q == ST_MUL) ? ({it_hi, it_lo} == '0) : (it_lo == '0);
                done_q     <= 1'b1;
                state_q    <= ST_IDLE;
            end
        end
    end

    assign ready     = (state_q == ST_IDLE);
    assign busy      = ~ready;
    assign done      = done_q;
    assign result_l  = result_l_q;
    assign result_h  = result_h_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign sign      = sign_q;
    assign div_err   = div_err_q;
    assign dbg_state = state_q;

endmodule
